// File: rtl/alu_seq.sv
// Registered ALU with a start/busy/done handshake; single-cycle ADD/SUB/NOR/shift ops.
// Define ALU_SEQ_MUL_EN to build the multi-cycle shift-add multiplier (MUL, opcode 0101).
module alu_seq #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_start,
    input  logic [3:0]        alu_select,
    input  logic [DATA_W-1:0] alu_a_in,
    input  logic [DATA_W-1:0] alu_b_in,
    output logic              alu_busy,
    output logic              alu_done,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] alu_out_hi,
    output logic              alu_carry_out,
    output logic              alu_zero_flag
);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_SHFR = 4'b1011;
    localparam logic [3:0] OP_SHFL = 4'b1100;

    logic [DATA_W-1:0] out_r;
    logic              carry_r;
    logic              zero_r;
    logic              done_r;

    logic [DATA_W-1:0] res_s;
    logic              c_s;
    logic              upd_s;

`ifdef ALU_SEQ_MUL_EN
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, MUL_RUN} state_t;

    state_t              state_r;
    logic                busy_r;
    logic [DATA_W-1:0]   hi_r;
    logic [DATA_W-1:0]   mcand_r;
    logic [2*DATA_W-1:0] acc_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W:0]     mul_sum_s;
    logic [2*DATA_W-1:0] acc_next_s;

    // One shift-add step: acc holds {partial high, remaining multiplier bits}
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*DATA_W-1:DATA_W]}
                   + (acc_r[0] ? {1'b0, mcand_r} : {(DATA_W+1){1'b0}});
        acc_next_s = {mul_sum_s, acc_r[DATA_W-1:1]};
    end

    assign alu_busy   = busy_r;
    assign alu_out_hi = hi_r;
`else
    assign alu_busy   = 1'b0;
    assign alu_out_hi = {DATA_W{1'b0}};
`endif

    // Single-cycle result; upd_s low means the op only pulses done and holds outputs
    always_comb begin
        res_s = {DATA_W{1'b0}};
        c_s   = 1'b0;
        upd_s = 1'b1;
        case (alu_select)
            OP_ADD:  {c_s, res_s} = {1'b0, alu_a_in} + {1'b0, alu_b_in};
            OP_SUB:  {c_s, res_s} = {1'b0, alu_a_in} - {1'b0, alu_b_in};
            OP_NOR:  res_s = ~(alu_a_in | alu_b_in);
            OP_SHFL: begin
                res_s = {alu_a_in[DATA_W-2:0], 1'b0};
                c_s   = alu_a_in[DATA_W-1];
            end
            OP_SHFR: begin
                res_s = {1'b0, alu_a_in[DATA_W-1:1]};
                c_s   = alu_a_in[0];
            end
            OP_NOP, OP_MUL: upd_s = 1'b0;
            default:        upd_s = 1'b0;
        endcase
    end

    // Accept handshake, result capture and multiply sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r   <= {DATA_W{1'b0}};
            carry_r <= 1'b0;
            zero_r  <= 1'b1;
            done_r  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            state_r <= IDLE;
            busy_r  <= 1'b0;
            hi_r    <= {DATA_W{1'b0}};
            mcand_r <= {DATA_W{1'b0}};
            acc_r   <= {(2*DATA_W){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
`endif
        end else begin
            done_r <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            case (state_r)
                IDLE: begin
                    if (alu_start && (alu_select == OP_MUL)) begin
                        state_r <= MUL_RUN;
                        busy_r  <= 1'b1;
                        mcand_r <= alu_a_in;
                        acc_r   <= {{DATA_W{1'b0}}, alu_b_in};
                        cnt_r   <= {CNT_W{1'b0}};
                    end else if (alu_start) begin
                        done_r <= 1'b1;
                        if (upd_s) begin
                            out_r   <= res_s;
                            hi_r    <= {DATA_W{1'b0}};
                            carry_r <= c_s;
                            zero_r  <= (res_s == {DATA_W{1'b0}});
                        end
                    end
                end
                MUL_RUN: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_ITER) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        out_r   <= acc_next_s[DATA_W-1:0];
                        hi_r    <= acc_next_s[2*DATA_W-1:DATA_W];
                        carry_r <= |acc_next_s[2*DATA_W-1:DATA_W];
                        zero_r  <= (acc_next_s == {(2*DATA_W){1'b0}});
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
`else
            if (alu_start) begin
                done_r <= 1'b1;
                if (upd_s) begin
                    out_r   <= res_s;
                    carry_r <= c_s;
                    zero_r  <= (res_s == {DATA_W{1'b0}});
                end
            end
`endif
        end
    end

    assign alu_done      = done_r;
    assign alu_out       = out_r;
    assign alu_carry_out = carry_r;
    assign alu_zero_flag = zero_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: stimulus pushes hand-computed expectations, a monitor
// pops one entry per done pulse and checks result, flags and completion cycle.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         alu_start = 1'b0;
    logic [3:0]   alu_select = 4'b0000;
    logic [W-1:0] alu_a_in = 8'h00;
    logic [W-1:0] alu_b_in = 8'h00;
    logic         alu_busy;
    logic         alu_done;
    logic [W-1:0] alu_out;
    logic [W-1:0] alu_out_hi;
    logic         alu_carry_out;
    logic         alu_zero_flag;

    alu_seq #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .alu_start(alu_start), .alu_select(alu_select),
        .alu_a_in(alu_a_in), .alu_b_in(alu_b_in), .alu_busy(alu_busy), .alu_done(alu_done),
        .alu_out(alu_out), .alu_out_hi(alu_out_hi), .alu_carry_out(alu_carry_out),
        .alu_zero_flag(alu_zero_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] o;
        logic [W-1:0] h;
        logic         c;
        logic         z;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   busy_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: one scoreboard entry is consumed per done pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (alu_busy) busy_seen = 1'b1;
            if (alu_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out",    32'(alu_out),       32'(e.o));
                    chk("out_hi", 32'(alu_out_hi),    32'(e.h));
                    chk("carry",  32'(alu_carry_out), 32'(e.c));
                    chk("zero",   32'(alu_zero_flag), 32'(e.z));
                    chk("done_cycle", 32'(cyc),       32'(e.cyc));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eo, input logic [W-1:0] eh,
                         input logic ec, input logic ez, input int lat);
        int budget;
        exp_t e;
        budget = 0;
        while (alu_busy && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (alu_busy) chk("busy_timeout", 32'd1, 32'd0);
        alu_select = op;
        alu_a_in   = a;
        alu_b_in   = b;
        alu_start  = 1'b1;
        e.o = eo; e.h = eh; e.c = ec; e.z = ez; e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk);
        alu_start  = 1'b0;
        alu_a_in   = ~a;
        alu_b_in   = ~b;
        alu_select = 4'b0001;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reset_state();
        chk("rst_out",   32'(alu_out),       32'h0);
        chk("rst_hi",    32'(alu_out_hi),    32'h0);
        chk("rst_carry", 32'(alu_carry_out), 32'h0);
        chk("rst_zero",  32'(alu_zero_flag), 32'h1);
        chk("rst_busy",  32'(alu_busy),      32'h0);
        chk("rst_done",  32'(alu_done),      32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk_reset_state();
        rst_n = 1'b1;
        @(negedge clk);

        issue(4'b0001, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 0); // ADD wraps
        issue(4'b0010, 8'h05, 8'h07, 8'hFE, 8'h00, 1'b1, 1'b0, 0); // SUB borrow
        issue(4'b0000, 8'h12, 8'h34, 8'hFE, 8'h00, 1'b1, 1'b0, 0); // NOP holds
        issue(4'b1100, 8'h81, 8'h00, 8'h02, 8'h00, 1'b1, 1'b0, 0); // SHFL
        issue(4'b1011, 8'h81, 8'h00, 8'h40, 8'h00, 1'b1, 1'b0, 0); // SHFR
        issue(4'b0011, 8'hF0, 8'h0F, 8'h00, 8'h00, 1'b0, 1'b1, 0); // NOR
        issue(4'b0001, 8'h12, 8'h34, 8'h46, 8'h00, 1'b0, 1'b0, 0); // ADD
        issue(4'b0111, 8'hAA, 8'h55, 8'h46, 8'h00, 1'b0, 1'b0, 0); // illegal holds
`ifdef ALU_SEQ_MUL_EN
        issue(4'b0101, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 8);
        // Start pulses while busy must be dropped
        alu_select = 4'b0001;
        alu_a_in   = 8'h01;
        alu_b_in   = 8'h01;
        alu_start  = 1'b1;
        repeat (2) @(negedge clk);
        alu_start  = 1'b0;
`else
        issue(4'b0101, 8'hFF, 8'hFF, 8'h46, 8'h00, 1'b0, 1'b0, 0);
`endif
        issue(4'b0001, 8'h01, 8'h02, 8'h03, 8'h00, 1'b0, 1'b0, 0); // back-to-back ADD
        issue(4'b0010, 8'h07, 8'h07, 8'h00, 8'h00, 1'b0, 1'b1, 0); // SUB equal
`ifdef ALU_SEQ_MUL_EN
        issue(4'b0101, 8'h03, 8'h04, 8'h0C, 8'h00, 1'b0, 1'b0, 8);
        issue(4'b0101, 8'h00, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b1, 8);
        issue(4'b0101, 8'h80, 8'h02, 8'h00, 8'h01, 1'b1, 1'b0, 8);
`else
        issue(4'b0101, 8'h03, 8'h04, 8'h00, 8'h00, 1'b0, 1'b1, 0);
`endif
        issue(4'b1011, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 0); // carry not in zero
        issue(4'b0001, 8'h10, 8'h20, 8'h30, 8'h00, 1'b0, 1'b0, 0);
        drain();

        // Asynchronous reset; with the multiplier built it lands mid-operation
`ifdef ALU_SEQ_MUL_EN
        issue(4'b0101, 8'hFF, 8'h02, 8'hFE, 8'h01, 1'b1, 1'b0, 8);
        repeat (2) @(negedge clk);
`endif
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk_reset_state();

        issue(4'b0001, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 0);
        drain();

`ifdef ALU_SEQ_MUL_EN
        chk("busy_seen", 32'(busy_seen), 32'd1);
`else
        chk("busy_seen", 32'(busy_seen), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
